// File: rtl/ihp_sram_bridge.sv
// ihp_sram_bridge
// Bridge between the IHP_SRAM fabric tile pair and the physical SRAM macro.
// After the fabric bitstream is loaded (cfg_done), the bridge can zero-clear
// the whole macro. It then forwards fabric accesses to the macro through one
// register stage, and returns held read data to the tile.
//
// Ports:
//   UserCLK     fabric user clock; all state updates on the rising edge
//   RESETn      asynchronous active-low reset
//   cfg_done    bitstream-loaded level flag (asynchronous, synchronized here)
//   clear_en    quasi-static; 1 = run the zero-clear sweep before RUN
//   fab_*       tile ADDR/DIN/BM/MEN/WEN/REN outputs
//   fab_dout    held read data returned to the tile
//   configured  drives the tile's CONFIGURED_top input
//   busy        clear sweep in progress
//   sram_*      registered macro controls; sram_dout is macro read data,
//               valid one cycle after a read is issued
module ihp_sram_bridge #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  UserCLK,
  input  logic                  RESETn,
  input  logic                  cfg_done,
  input  logic                  clear_en,
  input  logic [ADDR_WIDTH-1:0] fab_addr,
  input  logic [DATA_WIDTH-1:0] fab_din,
  input  logic [DATA_WIDTH-1:0] fab_bm,
  input  logic                  fab_men,
  input  logic                  fab_wen,
  input  logic                  fab_ren,
  output logic [DATA_WIDTH-1:0] fab_dout,
  output logic                  configured,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [DATA_WIDTH-1:0] sram_bm,
  output logic                  sram_men,
  output logic                  sram_wen,
  output logic                  sram_ren,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StClear = 2'b01,
    StRun   = 2'b10
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic                  cfg_meta_q, cfg_s_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  configured_q, configured_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0] sram_din_q, sram_din_d;
  logic [DATA_WIDTH-1:0] sram_bm_q, sram_bm_d;
  logic                  sram_men_q, sram_men_d;
  logic                  sram_wen_q, sram_wen_d;
  logic                  sram_ren_q, sram_ren_d;
  logic                  rd_pend_q;
  logic [DATA_WIDTH-1:0] fab_dout_q;

  // Two-flop synchronizer: cfg_done comes from the configuration domain.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      cfg_meta_q <= 1'b0;
      cfg_s_q    <= 1'b0;
    end else begin
      cfg_meta_q <= cfg_done;
      cfg_s_q    <= cfg_meta_q;
    end
  end

  // Next-state and next-output logic. configured and busy are computed for
  // the state being entered so they come straight from flops (no decode
  // glitches toward the fabric). Losing cfg_s always abandons the current
  // activity and parks the macro interface at zero.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    configured_d = 1'b0;
    busy_d       = 1'b0;
    sram_addr_d  = '0;
    sram_din_d   = '0;
    sram_bm_d    = '0;
    sram_men_d   = 1'b0;
    sram_wen_d   = 1'b0;
    sram_ren_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        clr_addr_d = '0;
        if (cfg_s_q) begin
          if (clear_en) begin
            state_d = StClear;
            busy_d  = 1'b1;
          end else begin
            state_d      = StRun;
            configured_d = 1'b1;
          end
        end
      end
      StClear: begin
        if (!cfg_s_q) begin
          state_d    = StIdle;
          clr_addr_d = '0;
        end else begin
          sram_addr_d = clr_addr_q;
          sram_bm_d   = '1;
          sram_men_d  = 1'b1;
          sram_wen_d  = 1'b1;
          // The sweep stops on the last word rather than wrapping, so DEPTH
          // smaller than the address space leaves the upper words untouched.
          if (clr_addr_q == LastAddr) begin
            state_d      = StRun;
            clr_addr_d   = '0;
            configured_d = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
            busy_d     = 1'b1;
          end
        end
      end
      StRun: begin
        if (!cfg_s_q) begin
          state_d = StIdle;
        end else begin
          configured_d = 1'b1;
          sram_addr_d  = fab_addr;
          sram_din_d   = fab_din;
          sram_bm_d    = fab_bm;
          sram_men_d   = fab_men;
          sram_wen_d   = fab_wen;
          sram_ren_d   = fab_ren;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, sweep counter and the registered macro interface.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= StIdle;
      clr_addr_q   <= '0;
      configured_q <= 1'b0;
      busy_q       <= 1'b0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
      sram_bm_q    <= '0;
      sram_men_q   <= 1'b0;
      sram_wen_q   <= 1'b0;
      sram_ren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      configured_q <= configured_d;
      busy_q       <= busy_d;
      sram_addr_q  <= sram_addr_d;
      sram_din_q   <= sram_din_d;
      sram_bm_q    <= sram_bm_d;
      sram_men_q   <= sram_men_d;
      sram_wen_q   <= sram_wen_d;
      sram_ren_q   <= sram_ren_d;
    end
  end

  // Read return: the macro presents data one cycle after the read is
  // issued, so a pending flag marks that cycle. The captured word is held
  // until the next read; only reset clears it.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      rd_pend_q  <= 1'b0;
      fab_dout_q <= '0;
    end else begin
      rd_pend_q <= sram_men_q & sram_ren_q;
      if (rd_pend_q) begin
        fab_dout_q <= sram_dout;
      end
    end
  end

  assign fab_dout   = fab_dout_q;
  assign configured = configured_q;
  assign busy       = busy_q;
  assign sram_addr  = sram_addr_q;
  assign sram_din   = sram_din_q;
  assign sram_bm    = sram_bm_q;
  assign sram_men   = sram_men_q;
  assign sram_wen   = sram_wen_q;
  assign sram_ren   = sram_ren_q;

endmodule
